fpu_pipe_arbiter: RTL

Issue controller and arbiter that shares one fixed-latency, fully pipelined FPU unit (finv-class: one operand in, one result out, no handshake of its own) between two requesters. It grants issue slots round-robin and tracks in-flight operations with a valid/tag shift register. Results land in an in-order result FIFO. Credit-based admission guarantees that no result is ever dropped under output backpressure. It sits between the core's FP issue stage and the unit instance.

---
 rtl/fpu_pipe_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fpu_pipe_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency, fully pipelined FPU between two requesters.
// Issue-to-result latency LATENCY+1; credits cover in-flight plus buffered results so the FIFO never overflows.
module fpu_pipe_arbiter #(
  parameter int LATENCY = 7,
  parameter int TAG_W   = 5,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_data,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_data,
  input  logic [TAG_W-1:0] r1_tag,
  output logic [31:0]      u_x,
  input  logic [31:0]      u_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             src;
  } res_t;

  logic [CW-1:0]                 r_count;
  logic [CW-1:0]                 r_occ;
  logic [PW-1:0]                 r_wr;
  logic [PW-1:0]                 r_rd;
  logic                          r_last;
  logic [LATENCY-1:0]            r_pv;
  logic [LATENCY-1:0]            r_psrc;
  logic [LATENCY-1:0][TAG_W-1:0] r_ptag;
  res_t                          r_mem [DEPTH];

  logic          w_cand;
  logic          w_pop;
  logic          w_push;
  logic          w_credit;
  logic          w_issue;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_occ_nxt;
  res_t          w_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // With both valid, the requester not granted last wins; a lone requester is always the candidate.
  assign w_cand   = (r0_valid && r1_valid) ? ~r_last : r1_valid;
  assign w_pop    = res_valid & res_ready;
  assign w_push   = r_pv[LATENCY-1] & ~flush;
  assign w_credit = (r_count < DEPTH_C) | w_pop;
  assign w_issue  = rstn & (r0_valid | r1_valid) & w_credit & ~flush;

  assign r0_ready = w_issue & ~w_cand;
  assign r1_ready = w_issue & w_cand;
  assign u_x      = w_issue ? (w_cand ? r1_data : r0_data) : 32'h0;

  assign w_head    = r_mem[r_rd];
  assign res_valid = (r_occ != '0);
  assign res_data  = res_valid ? w_head.data : 32'h0;
  assign res_tag   = res_valid ? w_head.tag  : '0;
  assign res_src   = res_valid ? w_head.src  : 1'b0;

  always_comb begin
    w_count_nxt = r_count;
    w_occ_nxt   = r_occ;
    if (w_issue && !w_pop)      w_count_nxt = r_count + CNT_ONE;
    else if (!w_issue && w_pop) w_count_nxt = r_count - CNT_ONE;
    if (w_push && !w_pop)       w_occ_nxt = r_occ + CNT_ONE;
    else if (!w_push && w_pop)  w_occ_nxt = r_occ - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
      r_occ   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_last  <= 1'b1;
      r_pv    <= '0;
      r_psrc  <= '0;
      r_ptag  <= '0;
    end else begin
      if (w_issue) r_last <= w_cand;
      r_psrc[0] <= w_cand;
      r_ptag[0] <= w_cand ? r1_tag : r0_tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_psrc[i] <= r_psrc[i-1];
        r_ptag[i] <= r_ptag[i-1];
      end
      // Flush drops tracked ops, so stale u_y values are never captured.
      if (flush) begin
        r_count <= '0;
        r_occ   <= '0;
        r_wr    <= '0;
        r_rd    <= '0;
        r_pv    <= '0;
      end else begin
        r_count <= w_count_nxt;
        r_occ   <= w_occ_nxt;
        r_pv[0] <= w_issue;
        for (int i = 1; i < LATENCY; i++) r_pv[i] <= r_pv[i-1];
        if (w_push) r_wr <= ptr_inc(r_wr);
        if (w_pop)  r_rd <= ptr_inc(r_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= '{data: u_y, tag: r_ptag[LATENCY-1], src: r_psrc[LATENCY-1]};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn || flush)
    !(w_push && (r_occ == DEPTH_C) && !w_pop));

endmodule
